// File: rtl/aes_pct_collector.sv
// aes_pct_collector
//   Assembles eight 16-bit cipher-core beats into one 128-bit result block
//   (first beat lands in the MSBs) and queues completed blocks in a 2-entry
//   FIFO. Malformed bursts and blocks dropped on a full FIFO raise sticky
//   error flags.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   pct_valid  beat valid from the cipher core
//   pct_first  first beat of a block (qualified by pct_valid)
//   pct_last   last beat of a block (qualified by pct_valid)
//   pct_data   16-bit beat payload
//   flag_clr   clears err_len / err_ovf (a same-cycle set wins)
//   out_valid  a result block is available at the FIFO head
//   out_ready  consumer accepts the head block when out_valid is high
//   out_data   128-bit block at the FIFO head
//   out_count  FIFO occupancy 0..2
//   room       high while out_count < 2
//   err_len    sticky malformed-burst flag
//   err_ovf    sticky FIFO-overflow flag
module aes_pct_collector (
    input  logic         clk,
    input  logic         rst,
    input  logic         pct_valid,
    input  logic         pct_first,
    input  logic         pct_last,
    input  logic [15:0]  pct_data,
    input  logic         flag_clr,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [1:0]   out_count,
    output logic         room,
    output logic         err_len,
    output logic         err_ovf
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;

    logic [2:0]     idx;
    logic [2:0]     idx_next;
    logic [127:0]   asm_reg;

    logic           store;
    logic [2:0]     wr_idx;
    logic [6:0]     wr_lo;
    logic           set_len;
    logic           push;
    logic [127:0]   push_data;

    logic [127:0]   mem [2];
    logic           wr_ptr;
    logic           rd_ptr;
    logic           pop;
    logic           do_write;
    logic           set_ovf;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        if (pct_valid) begin
            if (pct_first) begin
                // A first beat always (re)starts a block from any state;
                // first+last together is a one-beat block and is discarded.
                state_next = pct_last ? IDLE : COLLECT;
            end else begin
                case (state)
                    COLLECT: begin
                        if (pct_last) begin
                            state_next = IDLE;
                        end else if (idx == 3'd7) begin
                            state_next = DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (pct_last) begin
                            state_next = IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM: outputs (beat store, index update, length error, push)
    // ------------------------------------------------------------------
    always_comb begin
        store    = 1'b0;
        wr_idx   = idx;
        idx_next = idx;
        set_len  = 1'b0;
        push     = 1'b0;
        if (pct_valid) begin
            if (pct_first) begin
                store    = 1'b1;
                wr_idx   = '0;
                idx_next = pct_last ? 3'd0 : 3'd1;
                set_len  = pct_last || (state != IDLE);
            end else begin
                case (state)
                    COLLECT: begin
                        if (pct_last) begin
                            idx_next = '0;
                            if (idx == 3'd7) begin
                                store = 1'b1;
                                push  = 1'b1;
                            end else begin
                                set_len = 1'b1;
                            end
                        end else if (idx == 3'd7) begin
                            // Eighth beat without last: block would overrun.
                            set_len  = 1'b1;
                            idx_next = '0;
                        end else begin
                            store    = 1'b1;
                            idx_next = idx + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Beat k occupies bits [127-16k : 112-16k].
    assign wr_lo     = {3'd7 - wr_idx, 4'b0000};
    // The last beat is taken straight from the input so the block enters
    // the FIFO on the same edge that samples that beat.
    assign push_data = {asm_reg[127:16], pct_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= '0;
            asm_reg <= '0;
        end else begin
            idx <= idx_next;
            if (store) begin
                asm_reg[wr_lo +: 16] <= pct_data;
            end
        end
    end

    // ------------------------------------------------------------------
    // 2-entry result FIFO
    // ------------------------------------------------------------------
    assign out_valid = (out_count != 2'd0);
    assign room      = (out_count != 2'd2);
    assign out_data  = mem[rd_ptr];
    assign pop       = out_valid && out_ready;
    // When full, a simultaneous pop frees the head slot, which is the slot
    // wr_ptr points at, so the write proceeds.
    assign do_write  = push && (room || pop);
    assign set_ovf   = push && !room && !pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            out_count <= '0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_write, pop})
                2'b10:   out_count <= out_count + 2'd1;
                2'b01:   out_count <= out_count - 2'd1;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sticky error flags (set has priority over clear)
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            err_len <= 1'b0;
            err_ovf <= 1'b0;
        end else begin
            err_len <= set_len || (err_len && !flag_clr);
            err_ovf <= set_ovf || (err_ovf && !flag_clr);
        end
    end

endmodule

// File: tb/tb_aes_pct_collector.sv
`timescale 1ns/1ps
module tb_aes_pct_collector;

    logic         clk = 1'b0;
    logic         rst;
    logic         pct_valid;
    logic         pct_first;
    logic         pct_last;
    logic [15:0]  pct_data;
    logic         flag_clr;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [1:0]   out_count;
    logic         room;
    logic         err_len;
    logic         err_ovf;

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    aes_pct_collector dut (
        .clk       (clk),
        .rst       (rst),
        .pct_valid (pct_valid),
        .pct_first (pct_first),
        .pct_last  (pct_last),
        .pct_data  (pct_data),
        .flag_clr  (flag_clr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .room      (room),
        .err_len   (err_len),
        .err_ovf   (err_ovf)
    );

    // ------------------------------------------------------------------
    // Behavioural model: beats of the open block in a queue, results in a
    // queue of at most two blocks.
    // ------------------------------------------------------------------
    logic [15:0]  cur[$];
    logic [127:0] fifo[$];
    bit           open_blk = 1'b0;
    bit           skipping = 1'b0;
    bit           m_len    = 1'b0;
    bit           m_ovf    = 1'b0;
    bit           s_len;
    bit           s_ovf;
    bit           have_blk;
    logic [127:0] blk;

    always @(posedge clk) begin
        s_len    = 1'b0;
        s_ovf    = 1'b0;
        have_blk = 1'b0;
        blk      = '0;
        if (rst) begin
            cur.delete();
            fifo.delete();
            open_blk = 1'b0;
            skipping = 1'b0;
            m_len    = 1'b0;
            m_ovf    = 1'b0;
        end else begin
            if (pct_valid) begin
                if (pct_first) begin
                    if (open_blk || skipping || pct_last) s_len = 1'b1;
                    cur.delete();
                    skipping = 1'b0;
                    if (pct_last) begin
                        open_blk = 1'b0;
                    end else begin
                        cur.push_back(pct_data);
                        open_blk = 1'b1;
                    end
                end else if (skipping) begin
                    if (pct_last) skipping = 1'b0;
                end else if (open_blk) begin
                    if (pct_last) begin
                        open_blk = 1'b0;
                        if (cur.size() == 7) begin
                            for (int i = 0; i < 7; i++) blk = {blk[111:0], cur[i]};
                            blk = {blk[111:0], pct_data};
                            have_blk = 1'b1;
                        end else begin
                            s_len = 1'b1;
                        end
                    end else if (cur.size() == 7) begin
                        s_len    = 1'b1;
                        open_blk = 1'b0;
                        skipping = 1'b1;
                    end else begin
                        cur.push_back(pct_data);
                    end
                end
            end
            if (fifo.size() != 0 && out_ready) void'(fifo.pop_front());
            if (have_blk) begin
                if (fifo.size() < 2) fifo.push_back(blk);
                else s_ovf = 1'b1;
            end
            m_len = s_len || (m_len && !flag_clr);
            m_ovf = s_ovf || (m_ovf && !flag_clr);
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_count", 128'(out_count), 128'(fifo.size()));
            check("out_valid", 128'(out_valid), 128'(fifo.size() != 0));
            check("room", 128'(room), 128'(fifo.size() < 2));
            check("err_len", 128'(err_len), 128'(m_len));
            check("err_ovf", 128'(err_ovf), 128'(m_ovf));
            if (fifo.size() != 0) check("out_data", out_data, fifo[0]);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers (inputs change 1 ns after the rising edge)
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #2;
    endtask

    task automatic set_idle();
        pct_valid = 1'b0;
        pct_first = 1'($urandom);
        pct_last  = 1'($urandom);
        pct_data  = 16'($urandom);
    endtask

    task automatic beat(input bit f, input bit l, input logic [15:0] d);
        pct_valid = 1'b1;
        pct_first = f;
        pct_last  = l;
        pct_data  = d;
        tick();
        set_idle();
    endtask

    task automatic good_block(input logic [127:0] b, input bit gap);
        for (int k = 0; k < 8; k++) begin
            beat(k == 0, k == 7, b[127 - 16*k -: 16]);
            if (gap && k < 7) tick();
        end
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
    endtask

    task automatic clr_flags();
        flag_clr = 1'b1;
        tick();
        flag_clr = 1'b0;
    endtask

    function automatic logic [127:0] rand_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic rnd_ctl();
        out_ready = 1'($urandom);
        flag_clr  = ($urandom_range(0, 31) == 0);
        rst       = ($urandom_range(0, 499) == 0);
    endtask

    localparam logic [127:0] B0 = 128'h00112233445566778899AABBCCDDEEFF;

    logic [127:0] b1, b2, b3, b4, b5, b6, b7;
    logic [127:0] tmp;

    initial begin
        rst       = 1'b1;
        flag_clr  = 1'b0;
        out_ready = 1'b0;
        set_idle();
        tick(); tick(); tick();
        rst    = 1'b0;
        chk_en = 1'b1;

        // Reset state
        settle();
        check("rst_out_data", out_data, '0);
        check("rst_out_count", 128'(out_count), 128'd0);
        check("rst_room", 128'(room), 128'd1);
        check("rst_err_len", 128'(err_len), 128'd0);
        tick();

        // Nominal block
        good_block(B0, 1'b0);
        settle();
        check("nom_valid", 128'(out_valid), 128'd1);
        check("nom_data", out_data, B0);
        check("nom_count", 128'(out_count), 128'd1);
        tick();
        drain();

        // Gapped burst
        good_block(B0, 1'b1);
        settle();
        check("gap_data", out_data, B0);
        check("gap_err_len", 128'(err_len), 128'd0);
        tick();
        drain();

        // Short burst, flag clear, then a good block
        for (int k = 0; k < 6; k++) beat(k == 0, k == 5, 16'($urandom));
        settle();
        check("short_err_len", 128'(err_len), 128'd1);
        check("short_count", 128'(out_count), 128'd0);
        tick();
        clr_flags();
        settle();
        check("clr_err_len", 128'(err_len), 128'd0);
        tick();
        b1 = rand_blk();
        good_block(b1, 1'b0);
        settle();
        check("after_short_data", out_data, b1);
        tick();
        drain();

        // Overflow
        b1 = rand_blk(); b2 = rand_blk(); b3 = rand_blk();
        good_block(b1, 1'b0);
        good_block(b2, 1'b0);
        good_block(b3, 1'b0);
        settle();
        check("ovf_count", 128'(out_count), 128'd2);
        check("ovf_flag", 128'(err_ovf), 128'd1);
        check("ovf_head", out_data, b1);
        tick();
        out_ready = 1'b1;
        settle();
        check("deliver_1", out_data, b1);
        tick();
        settle();
        check("deliver_2", out_data, b2);
        tick();
        out_ready = 1'b0;
        settle();
        check("delivered_count", 128'(out_count), 128'd0);
        tick();

        // Full boundary: pop coincides with the push of the third block
        clr_flags();
        b4 = rand_blk(); b5 = rand_blk(); b6 = rand_blk();
        good_block(b4, 1'b0);
        good_block(b5, 1'b0);
        settle();
        check("full_count", 128'(out_count), 128'd2);
        tick();
        for (int k = 0; k < 7; k++) beat(k == 0, 1'b0, b6[127 - 16*k -: 16]);
        out_ready = 1'b1;
        beat(1'b0, 1'b1, b6[15:0]);
        out_ready = 1'b0;
        settle();
        check("bnd_err_ovf", 128'(err_ovf), 128'd0);
        check("bnd_count", 128'(out_count), 128'd2);
        check("bnd_head", out_data, b5);
        tick();
        out_ready = 1'b1;
        tick();
        settle();
        check("bnd_second", out_data, b6);
        tick();
        out_ready = 1'b0;

        // Restart on a reasserted first, then reset mid-burst
        b7 = rand_blk();
        beat(1'b1, 1'b0, 16'($urandom));
        beat(1'b0, 1'b0, 16'($urandom));
        beat(1'b0, 1'b0, 16'($urandom));
        good_block(b7, 1'b0);
        settle();
        check("restart_err_len", 128'(err_len), 128'd1);
        check("restart_data", out_data, b7);
        check("restart_count", 128'(out_count), 128'd1);
        tick();
        tmp = rand_blk();
        for (int k = 0; k < 4; k++) beat(k == 0, 1'b0, tmp[127 - 16*k -: 16]);
        rst = 1'b1;
        beat(1'b0, 1'b0, tmp[63:48]);
        rst = 1'b0;
        beat(1'b0, 1'b0, tmp[47:32]);
        beat(1'b0, 1'b0, tmp[31:16]);
        beat(1'b0, 1'b1, tmp[15:0]);
        settle();
        check("rst_mid_count", 128'(out_count), 128'd0);
        check("rst_mid_err_len", 128'(err_len), 128'd0);
        check("rst_mid_data", out_data, '0);
        tick();

        // Randomized bursts: mostly well-formed, some short/long/stray first
        for (int n = 0; n < 400; n++) begin
            int len;
            len = ($urandom_range(0, 9) < 6) ? 8 : int'($urandom_range(1, 11));
            for (int k = 0; k < len; k++) begin
                while ($urandom_range(0, 3) == 0) begin
                    rnd_ctl();
                    set_idle();
                    tick();
                end
                rnd_ctl();
                beat((k == 0 && $urandom_range(0, 19) != 0) || $urandom_range(0, 40) == 0,
                     k == len - 1, 16'($urandom));
            end
        end
        rst       = 1'b0;
        flag_clr  = 1'b0;
        out_ready = 1'b0;
        tick();
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
